// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and parity constants.
package uart_rx_pkg;

  // Frame-check FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Parity-type selector values.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bit counter width: covers up to 9 data bits and 2 stop bits.
  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_based_on_prescale,
  input  logic             asy_reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  // Count up on inc, hold at all-ones, clear on reset or clr.
  always_ff @(posedge clk_based_on_prescale) begin
    if (!asy_reset || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/frame_check.sv
// Checks one serial frame (data, optional parity, stop bits) from mid-bit samples
// and reports the word, per-frame error flags and saturating error counts.
module frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int STOP_BITS     = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_based_on_prescale,
  input  logic                     asy_reset,
  input  logic                     frame_start,
  input  logic                     bit_valid,
  input  logic                     sampled_data,
  input  logic                     par_en,
  input  logic                     par_type,
  input  logic                     err_cnt_clr,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     parity_error,
  output logic                     stop_error,
  output logic                     frame_done,
  output logic                     busy,
  output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] stop_err_cnt
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  state_t                  state_reg, state_next;
  logic [BIT_CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0]   data_out_reg;
  logic [DATA_WIDTH-1:0]   bit_sel;
  logic                    xor_reg;
  logic                    par_en_reg;
  logic                    par_type_reg;
  logic                    parity_error_reg;
  logic                    stop_error_reg;
  logic                    shift_en;

  // A data bit is taken only in DATA and never in a cycle that restarts the frame.
  assign shift_en = bit_valid && !frame_start && (state_reg == DATA);

  // One-hot decode of the bit counter selecting which data bit the sample lands in.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (bit_cnt_reg == BIT_CNT_W'(gi));
    end
  endgenerate

  // State and bit counter registers.
  always_ff @(posedge clk_based_on_prescale) begin
    if (!asy_reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  // Next-state, bit counting and frame status outputs; frame_start restarts from any state.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    busy         = (state_reg != IDLE);
    frame_done   = (state_reg == DONE);
    data_valid   = (state_reg == DONE) && !parity_error_reg && !stop_error_reg;
    if (frame_start) begin
      state_next   = DATA;
      bit_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end
        DATA: begin
          if (bit_valid) begin
            if (bit_cnt_reg == LAST_DATA) begin
              state_next   = par_en_reg ? PARITY : STOP;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_valid) begin
            state_next = STOP;
          end
        end
        STOP: begin
          if (bit_valid) begin
            if (bit_cnt_reg == LAST_STOP) begin
              state_next   = DONE;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next   = IDLE;
          bit_cnt_next = '0;
        end
      endcase
    end
  end

  // Per-frame datapath: settings capture, running XOR and error flags.
  always_ff @(posedge clk_based_on_prescale) begin
    if (!asy_reset) begin
      xor_reg          <= 1'b0;
      par_en_reg       <= 1'b0;
      par_type_reg     <= PAR_EVEN;
      parity_error_reg <= 1'b0;
      stop_error_reg   <= 1'b0;
    end else if (frame_start) begin
      xor_reg          <= 1'b0;
      par_en_reg       <= par_en;
      par_type_reg     <= par_type;
      parity_error_reg <= 1'b0;
      stop_error_reg   <= 1'b0;
    end else if (bit_valid) begin
      case (state_reg)
        DATA:    xor_reg <= xor_reg ^ sampled_data;
        PARITY:  parity_error_reg <= xor_reg ^ sampled_data ^ (par_type_reg == PAR_ODD);
        STOP:    if (!sampled_data) stop_error_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  // Assemble the word LSB first; bits hold until the next frame overwrites them.
  always_ff @(posedge clk_based_on_prescale) begin
    if (!asy_reset) begin
      data_out_reg <= '0;
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (shift_en && bit_sel[i]) begin
          data_out_reg[i] <= sampled_data;
        end
      end
    end
  end

  assign data_out     = data_out_reg;
  assign parity_error = parity_error_reg;
  assign stop_error   = stop_error_reg;

  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_par_cnt (
    .clk_based_on_prescale (clk_based_on_prescale),
    .asy_reset             (asy_reset),
    .inc                   (frame_done && parity_error_reg),
    .clr                   (err_cnt_clr),
    .count                 (par_err_cnt)
  );

  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_stop_cnt (
    .clk_based_on_prescale (clk_based_on_prescale),
    .asy_reset             (asy_reset),
    .inc                   (frame_done && stop_error_reg),
    .clr                   (err_cnt_clr),
    .count                 (stop_err_cnt)
  );

endmodule

// File: tb/tb_frame_check.sv
// Scoreboard bench for frame_check: one 8N1/8x1 instance (dut_a) and one
// 2-stop-bit instance with 2-bit counters (dut_b).
module tb_frame_check;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, fs, bv, sd, pen, ptype, clr, sel;
  logic fs_a, bv_a, clr_a, fs_b, bv_b, clr_b;

  assign fs_a  = fs  & ~sel;
  assign bv_a  = bv  & ~sel;
  assign clr_a = clr & ~sel;
  assign fs_b  = fs  &  sel;
  assign bv_b  = bv  &  sel;
  assign clr_b = clr &  sel;

  logic [7:0] do_a, do_b, pcnt_a, scnt_a;
  logic [1:0] pcnt_b, scnt_b;
  logic       dv_a, pe_a, se_a, fd_a, busy_a;
  logic       dv_b, pe_b, se_b, fd_b, busy_b;

  frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_WIDTH(8)) dut_a (
    .clk_based_on_prescale (clk),    .asy_reset (rst_n),
    .frame_start (fs_a), .bit_valid (bv_a), .sampled_data (sd),
    .par_en (pen), .par_type (ptype), .err_cnt_clr (clr_a),
    .data_out (do_a), .data_valid (dv_a), .parity_error (pe_a),
    .stop_error (se_a), .frame_done (fd_a), .busy (busy_a),
    .par_err_cnt (pcnt_a), .stop_err_cnt (scnt_a)
  );

  frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_WIDTH(2)) dut_b (
    .clk_based_on_prescale (clk),    .asy_reset (rst_n),
    .frame_start (fs_b), .bit_valid (bv_b), .sampled_data (sd),
    .par_en (pen), .par_type (ptype), .err_cnt_clr (clr_b),
    .data_out (do_b), .data_valid (dv_b), .parity_error (pe_b),
    .stop_error (se_b), .frame_done (fd_b), .busy (busy_b),
    .par_err_cnt (pcnt_b), .stop_err_cnt (scnt_b)
  );

  typedef struct {
    bit       which;
    logic [7:0] data;
    logic     pe;
    logic     se;
    logic     dv;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int exp_pcnt_a = 0, exp_scnt_a = 0, exp_pcnt_b = 0, exp_scnt_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int sat_inc(input int v, input int max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One gap cycle, then a one-cycle strobe; returns just after the sampling edge.
  task automatic strobe(input logic b);
    tick();
    sd = b;
    bv = 1'b1;
    tick();
    bv = 1'b0;
  endtask

  task automatic check_counters(input bit which);
    if (!which) begin
      check("par_cnt_a",  32'(pcnt_a), 32'(exp_pcnt_a));
      check("stop_cnt_a", 32'(scnt_a), 32'(exp_scnt_a));
    end else begin
      check("par_cnt_b",  32'(pcnt_b), 32'(exp_pcnt_b));
      check("stop_cnt_b", 32'(scnt_b), 32'(exp_scnt_b));
    end
  endtask

  // Drive one frame; abort_after >= 0 stops after that many data bits (no result expected).
  task automatic send_frame(input bit which, input logic [7:0] data, input bit p_en,
                            input bit p_type, input bit p_bit, input bit stop0,
                            input bit stop1, input int abort_after, input bit bv_on_start,
                            input bit clr_at_done);
    exp_t e;
    logic fd_s, busy_s;
    logic [7:0] do_s;
    sel   = which;
    fs    = 1'b1;
    pen   = p_en;
    ptype = p_type;
    bv    = bv_on_start;
    sd    = 1'b1;
    tick();
    fs    = 1'b0;
    bv    = 1'b0;
    pen   = ~p_en;
    ptype = ~p_type;
    busy_s = which ? busy_b : busy_a;
    check("busy_in_frame", 32'(busy_s), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_after) return;
      strobe(data[i]);
    end
    if (p_en) strobe(p_bit);
    e.which = which;
    e.data  = data;
    e.pe    = p_en & ((^data) ^ p_bit ^ p_type);
    e.se    = which ? (~stop0 | ~stop1) : ~stop0;
    e.dv    = ~e.pe & ~e.se;
    sb_q.push_back(e);
    strobe(stop0);
    if (which) strobe(stop1);
    fd_s = which ? fd_b : fd_a;
    check("frame_done_latency", 32'(fd_s), 32'd1);
    clr = clr_at_done;
    tick();
    clr = 1'b0;
    fd_s   = which ? fd_b : fd_a;
    busy_s = which ? busy_b : busy_a;
    do_s   = which ? do_b : do_a;
    check("frame_done_pulse", 32'(fd_s), 32'd0);
    check("busy_after_done", 32'(busy_s), 32'd0);
    check("data_hold", 32'(do_s), 32'(data));
    if (!which) begin
      exp_pcnt_a = clr_at_done ? 0 : (e.pe ? sat_inc(exp_pcnt_a, 255) : exp_pcnt_a);
      exp_scnt_a = clr_at_done ? 0 : (e.se ? sat_inc(exp_scnt_a, 255) : exp_scnt_a);
    end else begin
      exp_pcnt_b = clr_at_done ? 0 : (e.pe ? sat_inc(exp_pcnt_b, 3) : exp_pcnt_b);
      exp_scnt_b = clr_at_done ? 0 : (e.se ? sat_inc(exp_scnt_b, 3) : exp_scnt_b);
    end
    check_counters(which);
  endtask

  // Scoreboard consumer: every frame_done must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (fd_a) begin
      $display("frame dut_a data=%02h pe=%b se=%b dv=%b", do_a, pe_a, se_a, dv_a);
      if (sb_q.size() == 0) begin
        check("unexpected_frame_done_a", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_which_a", 32'(e.which), 32'd0);
        check("sb_data_a", 32'(do_a), 32'(e.data));
        check("sb_parity_err_a", 32'(pe_a), 32'(e.pe));
        check("sb_stop_err_a", 32'(se_a), 32'(e.se));
        check("sb_data_valid_a", 32'(dv_a), 32'(e.dv));
      end
    end
    if (fd_b) begin
      $display("frame dut_b data=%02h pe=%b se=%b dv=%b", do_b, pe_b, se_b, dv_b);
      if (sb_q.size() == 0) begin
        check("unexpected_frame_done_b", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_which_b", 32'(e.which), 32'd1);
        check("sb_data_b", 32'(do_b), 32'(e.data));
        check("sb_parity_err_b", 32'(pe_b), 32'(e.pe));
        check("sb_stop_err_b", 32'(se_b), 32'(e.se));
        check("sb_data_valid_b", 32'(dv_b), 32'(e.dv));
      end
    end
  end

  initial begin
    logic [7:0] rd;
    rst_n = 1'b0; fs = 1'b0; bv = 1'b0; sd = 1'b1;
    pen = 1'b0; ptype = 1'b0; clr = 1'b0; sel = 1'b0;
    repeat (3) tick();
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_data_a", 32'(do_a), 32'd0);
    check("rst_fd_a", 32'(fd_a), 32'd0);
    check("rst_dv_a", 32'(dv_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check_counters(1'b0);
    check_counters(1'b1);
    rst_n = 1'b1;
    tick();

    // 8N1 0xA5, good frame
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    // 8E1 0x03 with parity bit 1: parity error
    send_frame(1'b0, 8'h03, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    // 8O1 0x03 with parity bit 1: good
    send_frame(1'b0, 8'h03, 1'b1, PAR_ODD, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    // Abort after 4 bits, restart (with a colliding strobe) and send 0x5A
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1, 1'b0);
    // A few random frames
    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom_range(0, 255));
      send_frame(1'b0, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, -1, 1'b0, 1'b0);
    end
    // Stand-alone counter clear
    sel = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_pcnt_a = 0;
    exp_scnt_a = 0;
    check_counters(1'b0);

    // 8N2 0x3C, second stop bit low
    send_frame(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    // Four more stop errors: 2-bit counter saturates at 3
    for (int k = 0; k < 4; k++) begin
      send_frame(1'b1, 8'(k * 37), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    end
    // Sixth error with clear in the DONE cycle: clear wins
    send_frame(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1);

    // Reset while dut_a sits in PARITY
    sel = 1'b0;
    fs = 1'b1; pen = 1'b1; ptype = 1'b0;
    tick();
    fs = 1'b0;
    for (int i = 0; i < 8; i++) strobe(1'b1);
    check("busy_in_parity", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_pcnt_a = 0;
    exp_scnt_a = 0;
    check("rst_mid_busy", 32'(busy_a), 32'd0);
    check("rst_mid_data", 32'(do_a), 32'd0);
    check("rst_mid_fd", 32'(fd_a), 32'd0);
    check("rst_mid_dv", 32'(dv_a), 32'd0);
    check("rst_mid_pe", 32'(pe_a), 32'd0);
    check("rst_mid_se", 32'(se_a), 32'd0);
    check_counters(1'b0);
    strobe(1'b0);
    strobe(1'b1);
    check("rst_mid_no_done", 32'(fd_a), 32'd0);
    repeat (3) tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
